// File: rtl/moving_avg_filter.sv
// moving_avg_filter
//   Boxcar (moving-average) filter over the last 2^LOG2_TAPS accepted samples.
//   A circular history plus a running sum keeps the cost at one add and one
//   subtract per sample, independent of window length.
//
//   Parameters
//     DATA_W     sample width
//     LOG2_TAPS  log2 of window length N (legal range 1..6)
//
//   Ports
//     clk        system clock
//     rst_n      asynchronous active-low reset
//     in_valid   one-cycle strobe, in_data is valid
//     in_data    unsigned input sample
//     flush      synchronous clear of filter history (pulse or level)
//     out_valid  one-cycle strobe, out_data is valid (1 clk after in_valid)
//     out_data   unsigned filtered sample, sum of window >> LOG2_TAPS
//     warm       high once N samples have entered the window since reset/flush

module moving_avg_filter #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned LOG2_TAPS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              warm
);

    localparam int unsigned TAPS  = 1 << LOG2_TAPS;
    localparam int unsigned SUM_W = DATA_W + LOG2_TAPS;
    localparam int unsigned CNT_W = LOG2_TAPS + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAPS);

    typedef enum logic [0:0] {
        StFill,
        StRun
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0]    hist_q [TAPS];
    logic [LOG2_TAPS-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     fill_cnt_q, fill_cnt_d;
    logic [SUM_W-1:0]     sum_q, sum_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;

    logic              accept;
    logic [DATA_W-1:0] oldest;

    // Flush takes priority: a sample arriving alongside flush is dropped.
    assign accept = in_valid & ~flush;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StFill;
        end else begin
            unique case (state_q)
                StFill: begin
                    if (accept && (fill_cnt_d == FULL_CNT)) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    state_d = StRun;
                end
                default: begin
                    state_d = StFill;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        oldest = '0;
        warm   = 1'b0;
        unique case (state_q)
            StFill: begin
                // Unwritten history is don't-care, so nothing is subtracted yet.
                oldest = '0;
                warm   = 1'b0;
            end
            StRun: begin
                // Entry about to be overwritten is the one leaving the window.
                oldest = hist_q[wr_ptr_q];
                warm   = 1'b1;
            end
            default: begin
                oldest = '0;
                warm   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        sum_d       = sum_q;
        wr_ptr_d    = wr_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;

        if (flush) begin
            sum_d      = '0;
            wr_ptr_d   = '0;
            fill_cnt_d = '0;
        end else if (accept) begin
            // oldest is always already part of sum, so no underflow occurs.
            sum_d       = sum_q + SUM_W'(in_data) - SUM_W'(oldest);
            // Pointer is exactly LOG2_TAPS bits wide, so +1 wraps N-1 -> 0.
            wr_ptr_d    = wr_ptr_q + 1'b1;
            fill_cnt_d  = (fill_cnt_q == FULL_CNT) ? fill_cnt_q : fill_cnt_q + 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = DATA_W'(sum_d >> LOG2_TAPS);
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            sum_q       <= sum_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // History needs no reset: entries are only read once the window is full.
    always_ff @(posedge clk) begin
        if (accept) begin
            hist_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed self-checking bench for moving_avg_filter (DATA_W=12, N=8).

module tb_moving_avg_filter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_data;
    logic        flush;
    logic        out_valid;
    logic [11:0] out_data;
    logic        warm;

    int pass_cnt  = 0;
    int check_cnt = 0;

    moving_avg_filter #(
        .DATA_W   (12),
        .LOG2_TAPS(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_data (out_data),
        .warm     (warm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at #1 after a rising edge; returns at #1 after a rising edge.
    task automatic send(input string tag, input logic [11:0] d, input logic [11:0] exp_d,
                        input logic exp_w, input int gap);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".data"}, {20'd0, out_data}, {20'd0, exp_d});
        check({tag, ".warm"}, {31'd0, warm}, {31'd0, exp_w});
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, {31'd0, out_valid}, 32'd0);
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        logic [11:0] exp_d;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        flush    = 1'b0;
        #12;
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.data", {20'd0, out_data}, 32'd0);
        check("rst.warm", {31'd0, warm}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp-up with spaced strobes of 0x800.
        for (int k = 1; k <= 8; k++) begin
            exp_d = 12'(k * 32'h100);
            send("ramp", 12'h800, exp_d, (k == 8), 98);
        end

        // Drain with zeros: wrap-around removes oldest entries.
        for (int k = 1; k <= 8; k++) begin
            exp_d = 12'((8 - k) * 32'h100);
            send("drain", 12'h000, exp_d, 1'b1, 2);
        end

        // Ramp-up truncation.
        do_flush();
        check("flush.warm", {31'd0, warm}, 32'd0);
        send("trunc1", 12'd1, 12'd0, 1'b0, 0);
        send("trunc2", 12'd2, 12'd0, 1'b0, 0);
        send("trunc4", 12'd4, 12'd0, 1'b0, 0);
        send("trunc1b", 12'd1, 12'd1, 1'b0, 0);
        send("trunc0", 12'd0, 12'd1, 1'b0, 0);

        // 20 back-to-back samples of full scale.
        do_flush();
        in_valid = 1'b1;
        in_data  = 12'hFFF;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 20) in_valid = 1'b0;
            exp_d = 12'(((k < 8 ? k : 8) * 32'hFFF) >> 3);
            check("b2b.valid", {31'd0, out_valid}, 32'd1);
            check("b2b.data", {20'd0, out_data}, {20'd0, exp_d});
            check("b2b.warm", {31'd0, warm}, {31'd0, (k >= 8)});
        end
        @(posedge clk);
        #1;
        check("b2b.end", {31'd0, out_valid}, 32'd0);

        // Flush colliding with a sample.
        do_flush();
        for (int k = 1; k <= 8; k++) begin
            exp_d = 12'(k * 32'h80);
            send("fill400", 12'h400, exp_d, (k == 8), 1);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 12'hFFF;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fcol.valid", {31'd0, out_valid}, 32'd0);
        check("fcol.warm", {31'd0, warm}, 32'd0);
        check("fcol.hold", {20'd0, out_data}, 32'h400);
        send("post_flush", 12'h800, 12'h100, 1'b0, 1);
        for (int k = 2; k <= 8; k++) begin
            exp_d = 12'(k * 32'h100);
            send("refill", 12'h800, exp_d, (k == 8), 1);
        end

        // Asynchronous reset mid-stream, between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.data", {20'd0, out_data}, 32'd0);
        check("arst.warm", {31'd0, warm}, 32'd0);
        check("arst.valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send("post_rst", 12'h800, 12'h100, 1'b0, 1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/moving_avg_filter.md
Name: moving_avg_filter

Overview:
- Downstream consumer of the SPI ADC interface. Takes each 12-bit sample and its one-cycle valid strobe.
- Produces a boxcar (moving-average) filtered sample over the last 2^LOG2_TAPS inputs.
- Keeps a circular sample history and a running sum, so each output costs one add and one subtract regardless of tap count.
- Feeds the downstream display/processing logic.

Parameters:
- DATA_W, 12, sample width (matches ADC data width).
- LOG2_TAPS, 3, log2 of window length N (N = 8); legal range 1..6.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  one-cycle strobe; in_data is valid
- in_data  input  DATA_W  unsigned ADC sample
- flush  input  1  synchronous clear of filter history, one-cycle pulse or level
- out_valid  output  1  one-cycle strobe; out_data is valid
- out_data  output  DATA_W  unsigned filtered sample
- warm  output  1  high once N samples have entered the window since reset/flush

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, warm=0.
  - Internal state cleared: sum=0, wr_ptr=0, fill_cnt=0, state=FILL.
  - History RAM contents need not be cleared.
- Internal registers:
  - hist[0..N-1] of DATA_W bits.
  - wr_ptr of LOG2_TAPS bits; wraps N-1 -> 0.
  - fill_cnt of LOG2_TAPS+1 bits, saturating at N.
  - sum of DATA_W+LOG2_TAPS bits; cannot overflow.
- FSM has two states:
  - FILL: fill_cnt < N. The "oldest" operand is forced to 0, because unwritten history entries are don't-care.
  - RUN: window full. The oldest operand is hist[wr_ptr], read before overwrite in the same cycle.
  - FILL -> RUN on the accepted sample that makes fill_cnt == N.
  - RUN -> FILL only on flush or reset.
- On accepted sample (in_valid=1, flush=0), all in one clock edge:
  - sum_next = sum + in_data - oldest.
  - hist[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1 (mod N).
  - fill_cnt increments, saturating at N.
  - out_data <= sum_next >> LOG2_TAPS (truncation, no rounding); out_valid <= 1.
- Latency and throughput:
  - out_valid rises exactly 1 clk after in_valid. out_valid is 0 in every other cycle.
  - Accepts in_valid on consecutive cycles (full throughput); no backpressure.
- During FILL, outputs are produced and equal the sum of the received samples divided by N (ramp-up). warm=0.
- warm goes 1 in the same cycle as the out_valid for the Nth sample, and stays 1 until flush or reset.
- Flush:
  - On the next edge: sum=0, wr_ptr=0, fill_cnt=0, state=FILL, warm=0, out_valid=0.
  - out_data holds its last value.
- Simultaneous flush and in_valid: flush wins, the sample is discarded, and no out_valid is produced.
- Reset mid-window: all state is lost immediately; the first post-reset sample behaves as sample #1.
- in_valid held high: each cycle is a distinct sample (no edge detection required).

Test Plan:
- Reset then 8 strobes of in_data=0x800, spaced 100 clk apart -> out_data = 0x100, 0x200, ..., 0x800. Each out_valid is 1 clk after its in_valid. warm rises with the 8th output.
- Window full of 0x800, then 8 strobes of 0x000 -> out_data = 0x700, 0x600, ..., 0x000 (wrap-around removes the oldest entries correctly).
- 20 back-to-back strobes of 0xFFF -> after the 8th output, out_data=0xFFF on every cycle. sum reaches 0x7FF8 with no overflow; out_valid high for 20 consecutive cycles.
- Window full of 0x400, then flush together with in_valid (in_data=0xFFF) -> no out_valid and warm=0. The next sample 0x800 gives out_data=0x100.
- Ramp-up truncation check: samples 1, 2, 4 -> out_data = 0, 0, 0. Then samples 1, 0 -> sums 8 and 8 -> out_data = 1, 1.
- Assert rst_n low for 1 clk mid-stream while warm=1 -> outputs go to 0 asynchronously. The next sample 0x800 gives out_data=0x100 and warm=0.
